// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the RISC multi-cycle control sequencer and its ALU control decoder.
package risc_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLL = 4'd4,
        ALU_SRL = 4'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_LD    = 6'h02;
    localparam logic [5:0] OP_ST    = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JMP   = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;

endpackage

// File: rtl/risc_ctrl_fsm_if.sv
// Shared memory-port handshake between the control sequencer (master) and memory (slave).
interface risc_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic mem_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_sel, output mem_ready);
endinterface

// File: rtl/risc_alu_ctrl.sv
// Combinational opcode/func decode to ALU operation, immediate select and illegal flag.
module risc_alu_ctrl
    import risc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] alu_op,
    output logic       alu_src_imm,
    output logic       illegal
);

    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LD, OP_ST: alu_src_imm = 1'b1;
            OP_BEQ:                alu_op = ALU_SUB;
            OP_JMP, OP_HALT:       ;
            default:               illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RISC core.
// Optional memory wait timeout: define CTRL_MEM_TIMEOUT_EN.
module risc_ctrl_fsm
    import risc_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_STEP    = 4,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            opcode,
    input  logic [5:0]            func,
    input  logic                  alu_zero,
    risc_ctrl_fsm_if.master       mem_bus,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  ir_write,
    output logic                  dec_en,
    output logic [3:0]            alu_op,
    output logic                  alu_src_imm,
    output logic                  reg_write,
    output logic                  wb_sel,
    output logic                  halted,
    output logic                  illegal,
    output logic [2:0]            state
);

    if (ADDR_STEP == 0) begin : g_bad_addr_step
        $error("ADDR_STEP must be nonzero");
    end
    if (MEM_WAIT_MAX == 0) begin : g_bad_wait_max
        $error("MEM_WAIT_MAX must be nonzero");
    end

    state_t     state_q;
    logic       illegal_q;
    logic [3:0] ac_op;
    logic       ac_imm;
    logic       ac_ill;
    logic       mem_ready;
    logic       wait_expired;

    assign mem_ready = mem_bus.mem_ready;

    risc_alu_ctrl u_alu_ctrl (
        .opcode      (opcode),
        .func        (func),
        .alu_op      (ac_op),
        .alu_src_imm (ac_imm),
        .illegal     (ac_ill)
    );

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MEM_WAIT_MAX + 1);
    logic [CW-1:0] wait_cnt;
    // Expires on the MEM_WAIT_MAX-th consecutive unanswered request cycle.
    assign wait_expired = (wait_cnt == CW'(MEM_WAIT_MAX - 1)) && !mem_ready;
`else
    assign wait_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
`ifdef CTRL_MEM_TIMEOUT_EN
            wait_cnt <= '0;
            if ((state_q == FETCH || state_q == MEM) && !mem_ready && !wait_expired)
                wait_cnt <= wait_cnt + CW'(1);
`endif
            case (state_q)
                FETCH: begin
                    if (mem_ready)
                        state_q <= DECODE;
                    else if (wait_expired) begin
                        state_q   <= HALT;
                        illegal_q <= 1'b1;
                    end
                end
                DECODE: state_q <= EXECUTE;
                EXECUTE: begin
                    if (ac_ill) begin
                        state_q   <= HALT;
                        illegal_q <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_RTYPE, OP_ADDI: state_q <= WRITEBACK;
                            OP_LD, OP_ST:      state_q <= MEM;
                            OP_HALT:           state_q <= HALT;
                            default:           state_q <= FETCH;
                        endcase
                    end
                end
                MEM: begin
                    if (mem_ready)
                        state_q <= (opcode == OP_LD) ? WRITEBACK : FETCH;
                    else if (wait_expired) begin
                        state_q   <= HALT;
                        illegal_q <= 1'b1;
                    end
                end
                WRITEBACK: state_q <= FETCH;
                HALT:      state_q <= HALT;
                default:   state_q <= FETCH;
            endcase
        end
    end

    // Outputs follow the state register directly and are forced low during reset.
    always_comb begin
        pc_write         = 1'b0;
        pc_src           = PC_SEQ;
        ir_write         = 1'b0;
        dec_en           = 1'b0;
        alu_op           = ALU_ADD;
        alu_src_imm      = 1'b0;
        mem_bus.mem_req  = 1'b0;
        mem_bus.mem_we   = 1'b0;
        mem_bus.mem_sel  = 1'b0;
        reg_write        = 1'b0;
        wb_sel           = 1'b0;
        halted           = 1'b0;
        illegal          = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_bus.mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                DECODE: dec_en = 1'b1;
                EXECUTE: begin
                    alu_op      = ac_op;
                    alu_src_imm = ac_imm;
                    if (opcode == OP_BEQ && alu_zero) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BRANCH;
                    end else if (opcode == OP_JMP) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                end
                MEM: begin
                    mem_bus.mem_req = 1'b1;
                    mem_bus.mem_sel = 1'b1;
                    mem_bus.mem_we  = (opcode == OP_ST);
                end
                WRITEBACK: begin
                    reg_write = 1'b1;
                    wb_sel    = (opcode == OP_LD);
                end
                HALT: begin
                    halted  = 1'b1;
                    illegal = illegal_q;
                end
                default: ;
            endcase
        end
    end

    assign state = reset ? FETCH : state_q;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed bench for risc_ctrl_fsm: per-cycle expected trace built from instruction-level rules.
module tb_risc_ctrl_fsm;
    import risc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       alu_zero = 1'b0;
    logic       pc_write, ir_write, dec_en, alu_src_imm, reg_write, wb_sel, halted, illegal;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic [2:0] state;

    risc_ctrl_fsm_if bus ();

    risc_ctrl_fsm #(.ADDR_STEP(4), .MEM_WAIT_MAX(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .func        (func),
        .alu_zero    (alu_zero),
        .mem_bus     (bus.master),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .ir_write    (ir_write),
        .dec_en      (dec_en),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .halted      (halted),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       dec;
        logic [3:0] alu;
        logic       imm;
        logic       req;
        logic       we;
        logic       sel;
        logic       rw;
        logic       wb;
        logic       hlt;
        logic       ill;
    } rec_t;

    rec_t  act;
    rec_t  expq[$];
    string tagq[$];
    rec_t  trace[$];
    int    n_chk = 0;
    int    n_fail = 0;

    assign act = {state, pc_write, pc_src, ir_write, dec_en, alu_op, alu_src_imm,
                  bus.mem_req, bus.mem_we, bus.mem_sel, reg_write, wb_sel, halted, illegal};

    always @(negedge clk) begin
        rec_t  e;
        string t;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            trace.push_back(act);
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s @%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                         t, $time, act.st, act, e.st, e);
            end
        end
    end

    function automatic void chk(string nm, int got, int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endfunction

    // R-type func codes listed in ALU-code order; position in the table is the alu_op.
    function automatic int rtype_code(logic [5:0] fn);
        logic [5:0] tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00, 6'h02};
        for (int i = 0; i < 6; i++)
            if (tab[i] == fn) return i;
        return -1;
    endfunction

    function automatic rec_t r_fetch(bit rdy);
        rec_t r = '0;
        r.req = 1'b1;
        r.irw = rdy;
        r.pcw = rdy;
        return r;
    endfunction

    function automatic rec_t r_decode();
        rec_t r = '0;
        r.st  = 3'd1;
        r.dec = 1'b1;
        return r;
    endfunction

    function automatic rec_t r_exec(logic [5:0] op, logic [5:0] fn, bit z);
        rec_t r = '0;
        r.st = 3'd2;
        if (op == 6'h00 && rtype_code(fn) >= 0) r.alu = 4'(rtype_code(fn));
        if (op == 6'h01 || op == 6'h02 || op == 6'h03) r.imm = 1'b1;
        if (op == 6'h04) begin
            r.alu = 4'd1;
            r.pcw = z;
            r.pcs = z ? 2'd1 : 2'd0;
        end
        if (op == 6'h05) begin
            r.pcw = 1'b1;
            r.pcs = 2'd2;
        end
        return r;
    endfunction

    function automatic rec_t r_mem(logic [5:0] op);
        rec_t r = '0;
        r.st  = 3'd3;
        r.req = 1'b1;
        r.sel = 1'b1;
        r.we  = (op == 6'h03);
        return r;
    endfunction

    function automatic rec_t r_wb(logic [5:0] op);
        rec_t r = '0;
        r.st = 3'd4;
        r.rw = 1'b1;
        r.wb = (op == 6'h02);
        return r;
    endfunction

    function automatic rec_t r_halt(bit ill);
        rec_t r = '0;
        r.st  = 3'd5;
        r.hlt = 1'b1;
        r.ill = ill;
        return r;
    endfunction

    task automatic cyc(bit rdy, rec_t e, string tag);
        bus.mem_ready = rdy;
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), '0, "reset");
        reset = 1'b0;
    endtask

    // One full instruction: fw/mw unanswered cycles in FETCH/MEM, hc cycles observed in HALT.
    task automatic run(logic [5:0] op, logic [5:0] fn, bit z, int fw, int mw, int hc);
        bit legal_r;
        opcode   = op;
        func     = fn;
        alu_zero = z;
        legal_r  = (rtype_code(fn) >= 0);
        for (int i = 0; i < fw; i++) cyc(1'b0, r_fetch(1'b0), "fetch_wait");
        cyc(1'b1, r_fetch(1'b1), "fetch");
        cyc(1'b1, r_decode(), "decode");
        cyc(1'b0, r_exec(op, fn, z), "execute");
        if ((op == 6'h00 && legal_r) || op == 6'h01) begin
            cyc(1'b1, r_wb(op), "writeback");
        end else if (op == 6'h02 || op == 6'h03) begin
            for (int i = 0; i < mw; i++) cyc(1'b0, r_mem(op), "mem_wait");
            cyc(1'b1, r_mem(op), "mem");
            if (op == 6'h02) cyc(1'b0, r_wb(op), "writeback");
        end else if (op == 6'h3F) begin
            for (int i = 0; i < hc; i++) cyc(1'($urandom_range(0, 1)), r_halt(1'b0), "halt");
        end else if (op != 6'h04 && op != 6'h05) begin
            for (int i = 0; i < hc; i++) cyc(1'($urandom_range(0, 1)), r_halt(1'b1), "halt_illegal");
        end
    endtask

    function automatic int count_memdata();
        int n = 0;
        foreach (trace[i]) if (trace[i].req && trace[i].sel) n++;
        return n;
    endfunction

    function automatic int count_halt_ill();
        int n = 0;
        foreach (trace[i]) if (trace[i].hlt && trace[i].ill) n++;
        return n;
    endfunction

    initial begin
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);
        chk("reset_state", int'(trace[$].st), 0);
        chk("reset_vec_zero", int'(trace[$]), 0);

        trace.delete();
        run(6'h00, 6'h20, 1'b0, 0, 0, 0);
        chk("add_latency", trace.size(), 4);
        chk("add_st_seq", int'({trace[0].st, trace[1].st, trace[2].st, trace[3].st}), 12'o0124);
        chk("add_alu_op", int'(trace[2].alu), 0);
        chk("add_reg_write", int'(trace[3].rw), 1);
        chk("add_wb_sel", int'(trace[3].wb), 0);

        run(6'h00, 6'h22, 1'b0, 2, 0, 0);
        run(6'h00, 6'h24, 1'b1, 0, 0, 0);
        run(6'h00, 6'h25, 1'b0, 1, 0, 0);
        run(6'h00, 6'h00, 1'b0, 0, 0, 0);
        run(6'h00, 6'h02, 1'b0, 0, 0, 0);
        trace.delete();
        run(6'h01, 6'h11, 1'b0, 0, 0, 0);
        chk("addi_latency", trace.size(), 4);
        chk("addi_imm", int'(trace[2].imm), 1);

        trace.delete();
        run(6'h02, 6'h00, 1'b0, 0, 3, 0);
        chk("ld_memdata_cycles", count_memdata(), 4);
        chk("ld_wb_sel", int'(trace[$].wb), 1);
        trace.delete();
        run(6'h02, 6'h00, 1'b0, 0, 0, 0);
        chk("ld_latency", trace.size(), 5);
        trace.delete();
        run(6'h03, 6'h00, 1'b0, 0, 0, 0);
        chk("st_latency", trace.size(), 4);
        chk("st_mem_we", int'(trace[3].we), 1);
        run(6'h03, 6'h00, 1'b1, 1, 2, 0);

        trace.delete();
        run(6'h04, 6'h00, 1'b1, 0, 0, 0);
        chk("beq_taken_latency", trace.size(), 3);
        chk("beq_taken_pcw", int'(trace[2].pcw), 1);
        chk("beq_taken_pcs", int'(trace[2].pcs), 1);
        trace.delete();
        run(6'h04, 6'h00, 1'b0, 0, 0, 0);
        chk("beq_nt_latency", trace.size(), 3);
        chk("beq_nt_pcw", int'(trace[2].pcw), 0);
        trace.delete();
        run(6'h05, 6'h00, 1'b0, 0, 0, 0);
        chk("jmp_pcs", int'(trace[2].pcs), 2);

`ifndef CTRL_MEM_TIMEOUT_EN
        run(6'h02, 6'h00, 1'b0, 20, 20, 0);
`endif

        run(6'h00, 6'h3F, 1'b0, 0, 0, 5);
        do_reset(1);
        run(6'h3F, 6'h00, 1'b0, 0, 0, 5);
        do_reset(1);

        trace.delete();
        run(6'h2A, 6'h00, 1'b0, 0, 0, 10);
        chk("illegal_halt_cycles", count_halt_ill(), 10);
        do_reset(1);
        chk("post_halt_reset_vec", int'(trace[$]), 0);

        // Reset while a store is waiting on memory.
        opcode = 6'h03;
        cyc(1'b1, r_fetch(1'b1), "st_fetch");
        cyc(1'b0, r_decode(), "st_decode");
        cyc(1'b0, r_exec(6'h03, 6'h00, 1'b0), "st_execute");
        cyc(1'b0, r_mem(6'h03), "st_mem_wait");
        cyc(1'b0, r_mem(6'h03), "st_mem_wait");
        trace.delete();
        do_reset(1);
        chk("st_reset_req", int'(trace[0].req), 0);
        chk("st_reset_we", int'(trace[0].we), 0);
        trace.delete();
        run(6'h00, 6'h20, 1'b0, 0, 0, 0);
        chk("after_reset_first_state", int'(trace[0].st), 0);

`ifdef CTRL_MEM_TIMEOUT_EN
        trace.delete();
        opcode = 6'h00;
        for (int i = 0; i < 15; i++) cyc(1'b0, r_fetch(1'b0), "fetch_timeout_wait");
        for (int i = 0; i < 4; i++) cyc(1'b1, r_halt(1'b1), "fetch_timeout_halt");
        chk("timeout_halt_ill", count_halt_ill(), 4);
        chk("timeout_wait_len", count_memdata() + int'(trace[14].req), 1);
        do_reset(1);
        trace.delete();
        run(6'h02, 6'h00, 1'b0, 14, 14, 0);
        chk("timeout_just_below", trace.size(), 33);
`endif

        run(6'h01, 6'h00, 1'b0, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_ctrl_fsm.md
Name: risc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RISC core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It drives the enables for the PC, the instruction register, the registered instruction decoder, the ALU, the shared memory port and the register file. It consumes opcode/func from the decoder's registered outputs and owns the single memory-port handshake.

Parameters:
- ADDR_STEP, default 4: PC increment per sequential instruction, in bytes.
- MEM_WAIT_MAX, default 15: timeout cycle limit. Used only when CTRL_MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  from the decoder, valid from EXECUTE onward
- func  in  6  from the decoder, R-type function code
- alu_zero  in  1  ALU zero flag, valid in EXECUTE
- mem_ready  in  1  memory acknowledges the current request
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 0 = PC+ADDR_STEP, 1 = branch target, 2 = jump target
- ir_write  out  1  latch the fetched instruction
- dec_en  out  1  decoder/register-file sample strobe
- alu_op  out  4  ALU operation (package encoding)
- alu_src_imm  out  1  ALU operand B = sign-extended immediate
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_sel  out  1  0 = instruction access, 1 = data access
- reg_write  out  1  register-file write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  core stopped
- illegal  out  1  stopped because of an undecodable opcode/func
- state  out  3  current state, for debug

Behaviour:
- Reset:
  - state = FETCH.
  - Every output is 0 while reset is high, including halted, illegal and alu_op. state reads FETCH.
  - Reset mid-operation abandons the instruction in the same cycle and drops mem_req.
- Outputs are decoded combinationally from the state register and the opcode/func inputs. No output register stage.
- FETCH:
  - mem_req=1, mem_sel=0, mem_we=0.
  - Hold until mem_ready=1. In that cycle ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: dec_en=1 for exactly one cycle, then EXECUTE. Decoder outputs are valid in the following cycle.
- EXECUTE (decode by opcode):
  - 0x00 R-type → WRITEBACK. Func mapping: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x00 SLL, 0x02 SRL. Any other func is illegal.
  - 0x01 ADDI: alu_src_imm=1, ADD → WRITEBACK.
  - 0x02 LD and 0x03 ST: alu_src_imm=1, ADD → MEM.
  - 0x04 BEQ: alu_op=SUB. If alu_zero=1 then pc_write=1, pc_src=1. Next state FETCH.
  - 0x05 JMP: pc_write=1, pc_src=2. Next state FETCH.
  - 0x3F HALT → HALT.
  - Any other opcode → HALT with illegal=1.
- MEM:
  - mem_req=1, mem_sel=1, mem_we=1 for ST.
  - Hold until mem_ready. Then LD → WRITEBACK, ST → FETCH.
- WRITEBACK: reg_write=1, wb_sel=1 for LD, else 0. Next state FETCH.
- HALT:
  - halted=1 and no enables asserted.
  - The state is left only by reset. illegal is sticky until reset.
- Latency with mem_ready held high:
  - R-type/ADDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - BEQ/JMP: 3 cycles.
- Handshake rules:
  - mem_req stays high and mem_sel/mem_we stay stable until the cycle mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
- Invariants:
  - pc_write and reg_write are never asserted in the same cycle.
  - At most one state transition per cycle.

Optional Feature:
CTRL_MEM_TIMEOUT_EN
- Defined: a wait counter counts FETCH/MEM cycles with mem_ready=0. When it reaches MEM_WAIT_MAX the FSM enters HALT with illegal=1 and mem_req drops. The counter clears on every state change and on reset.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Package risc_ctrl_pkg holds:
  - the state enum: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5;
  - opcode constants;
  - func constants;
  - alu_op encoding: ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5;
  - pc_src encoding.
- One sub-module, risc_alu_ctrl: combinational opcode/func → alu_op, alu_src_imm and an illegal flag. Shared with the ALU bench.

Test Plan:
- R-type ADD (opcode 0x00, func 0x20), mem_ready tied high → states 0,1,2,4,0. alu_op=0 in EXECUTE. reg_write=1 in cycle 4, wb_sel=0.
- LD (0x02) with mem_ready low for 3 cycles in MEM → mem_req=1, mem_sel=1 held for 4 cycles. Then WRITEBACK with wb_sel=1.
- BEQ (0x04) twice, alu_zero=1 then alu_zero=0 → pc_write=1, pc_src=1 in EXECUTE for the first; no pc_write in EXECUTE for the second. Each takes 3 cycles.
- Opcode 0x2A → HALT, halted=1 and illegal=1, held for 10 cycles. Reset then returns state to 0 with all outputs 0.
- Reset asserted in MEM during a ST → next cycle state=0, mem_req=0, mem_we=0.
- With CTRL_MEM_TIMEOUT_EN defined, hold mem_ready=0 in FETCH → halted=1 and illegal=1 after 15 wait cycles.
